// File: rtl/axis_delay_line.sv
// AXI-Stream fixed-latency delay line: LATENCY retimed stages carrying data/user/last with per-stage valid.
// Optional AXIS_DELAY_SKID_EN adds a 2-entry output skid so s_axis_tready is registered.
module axis_delay_line #(
  parameter int DATA_W  = 128,
  parameter int USER_W  = 1,
  parameter int LATENCY = 9,
  localparam int CNT_W  = $clog2(LATENCY + 3)
) (
  input  logic              aclk,
  input  logic              arstn,
  input  logic              flush,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [USER_W-1:0] s_axis_tuser,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [USER_W-1:0] m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [CNT_W-1:0]  occupancy
);

  logic [DATA_W-1:0] st_data [LATENCY];
  logic [USER_W-1:0] st_user [LATENCY];
  logic [LATENCY-1:0] st_last;
  logic [LATENCY-1:0] st_vld;
  logic advance;
  logic in_xfer;
  logic out_xfer;

  assign in_xfer = s_axis_tvalid & s_axis_tready;

  // Payload registers carry no reset; only the valid chain qualifies them.
  always_ff @(posedge aclk) begin
    if (advance) begin
      st_data[0] <= s_axis_tdata;
      st_user[0] <= s_axis_tuser;
      st_last[0] <= s_axis_tlast;
      for (int k = 1; k < LATENCY; k++) begin
        st_data[k] <= st_data[k-1];
        st_user[k] <= st_user[k-1];
        st_last[k] <= st_last[k-1];
      end
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      st_vld <= '0;
    end else if (flush) begin
      st_vld <= '0;
    end else if (advance) begin
      st_vld[0] <= in_xfer;
      for (int k = 1; k < LATENCY; k++) begin
        st_vld[k] <= st_vld[k-1];
      end
    end
  end

`ifdef AXIS_DELAY_SKID_EN
  logic [DATA_W-1:0] sk_data [2];
  logic [USER_W-1:0] sk_user [2];
  logic [1:0] sk_last;
  logic [1:0] skid_count;
  logic [1:0] skid_count_next;
  logic [1:0] wr_pos;
  logic ready_q;
  logic push;
  logic pop;

  // The pipe only moves when the skid is guaranteed a free slot, decided a cycle early.
  assign advance       = ready_q & !flush;
  assign s_axis_tready = advance;
  assign push          = advance & st_vld[LATENCY-1];
  assign pop           = (skid_count != 2'd0) & m_axis_tready;
  assign wr_pos        = skid_count - {1'b0, pop};
  assign out_xfer      = pop;

  always_comb begin
    skid_count_next = skid_count + {1'b0, push} - {1'b0, pop};
    if (flush) skid_count_next = 2'd0;
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      skid_count <= 2'd0;
      ready_q    <= 1'b0;
    end else begin
      skid_count <= skid_count_next;
      ready_q    <= (skid_count_next < 2'd2) & !flush;
    end
  end

  // Head is always entry 0; a simultaneous push lands after the shifted entry.
  always_ff @(posedge aclk) begin
    if (pop) begin
      sk_data[0] <= sk_data[1];
      sk_user[0] <= sk_user[1];
      sk_last[0] <= sk_last[1];
    end
    if (push) begin
      sk_data[wr_pos[0]] <= st_data[LATENCY-1];
      sk_user[wr_pos[0]] <= st_user[LATENCY-1];
      sk_last[wr_pos[0]] <= st_last[LATENCY-1];
    end
  end

  assign m_axis_tdata  = sk_data[0];
  assign m_axis_tuser  = sk_user[0];
  assign m_axis_tlast  = sk_last[0];
  assign m_axis_tvalid = (skid_count != 2'd0);
`else
  assign advance       = !flush & (m_axis_tready | !st_vld[LATENCY-1]);
  assign s_axis_tready = advance;
  assign m_axis_tdata  = st_data[LATENCY-1];
  assign m_axis_tuser  = st_user[LATENCY-1];
  assign m_axis_tlast  = st_last[LATENCY-1];
  assign m_axis_tvalid = st_vld[LATENCY-1];
  assign out_xfer      = m_axis_tvalid & m_axis_tready;
`endif

  // Beats moving from pipe into skid stay counted; only the boundary transfers change the total.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if (in_xfer && !out_xfer) begin
      occupancy <= occupancy + CNT_W'(1);
    end else if (!in_xfer && out_xfer) begin
      occupancy <= occupancy - CNT_W'(1);
    end
  end

endmodule
